// File: rtl/word_serializer.sv
// 32-bit word serializer that steers an external 32-to-1 mux (input_lines/selector_bits -> output_line).
// Optional trailing even-parity beat enabled by defining SERIAL_PARITY_EN.
module word_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [31:0] input_lines,
  output logic [4:0]  selector_bits,
  input  logic        output_line,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        bit_last,
  output logic        busy
);

`ifdef SERIAL_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;
`else
  localparam bit HAS_PARITY = 1'b0;
`endif

  localparam logic [4:0] SEL_START     = MSB_FIRST ? 5'd31 : 5'd0;
  localparam logic [5:0] LAST_DATA_IDX = 6'd31;
  localparam logic [5:0] PRE_LAST_IDX  = 6'd30;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
`ifdef SERIAL_PARITY_EN
    PARITY = 2'b10,
`endif
    SHIFT  = 2'b01
  } state_t;

  state_t      state_r;
  logic [31:0] input_lines_r;
  logic [4:0]  selector_r;
  logic [5:0]  beat_cnt_r;
  logic        bit_valid_r;
  logic        bit_last_r;
  logic        busy_r;
  logic        beat_xfer_s;
  logic [4:0]  sel_next_s;

`ifdef SERIAL_PARITY_EN
  logic        parity_r;

  function automatic logic even_parity(input logic [31:0] w);
    return ^w;
  endfunction
`endif

  assign beat_xfer_s = bit_valid_r & bit_ready;
  assign sel_next_s  = MSB_FIRST ? (selector_r - 5'd1) : (selector_r + 5'd1);

  // Ready is withheld while reset is asserted even though the state is already IDLE.
  assign word_ready    = (state_r == IDLE) & ~reset;
  assign input_lines   = input_lines_r;
  assign selector_bits = selector_r;
  assign bit_valid     = bit_valid_r;
  assign bit_last      = bit_last_r;
  assign busy          = busy_r;

`ifdef SERIAL_PARITY_EN
  assign bit_out = (state_r == PARITY) ? parity_r : output_line;
`else
  assign bit_out = output_line;
`endif

  // Serializer FSM: capture, beat stepping under backpressure, optional parity beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      input_lines_r <= 32'h0000_0000;
      selector_r    <= 5'd0;
      beat_cnt_r    <= 6'd0;
      bit_valid_r   <= 1'b0;
      bit_last_r    <= 1'b0;
      busy_r        <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (word_valid) begin
            state_r       <= SHIFT;
            input_lines_r <= word_in;
            selector_r    <= SEL_START;
            beat_cnt_r    <= 6'd0;
            bit_valid_r   <= 1'b1;
            bit_last_r    <= 1'b0;
            busy_r        <= 1'b1;
`ifdef SERIAL_PARITY_EN
            parity_r      <= even_parity(word_in);
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (beat_xfer_s) begin
            beat_cnt_r <= beat_cnt_r + 6'd1;
            // Selector holds on the terminal beat so it never wraps within a word.
            if (beat_cnt_r == LAST_DATA_IDX) begin
`ifdef SERIAL_PARITY_EN
              state_r     <= PARITY;
              bit_last_r  <= 1'b1;
`else
              state_r     <= IDLE;
              bit_valid_r <= 1'b0;
              bit_last_r  <= 1'b0;
              busy_r      <= 1'b0;
`endif
            end else begin
              selector_r <= sel_next_s;
              bit_last_r <= ~HAS_PARITY & (beat_cnt_r == PRE_LAST_IDX);
            end
          end else begin
            state_r <= SHIFT;
          end
        end
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          if (beat_xfer_s) begin
            state_r     <= IDLE;
            bit_valid_r <= 1'b0;
            bit_last_r  <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= PARITY;
          end
        end
`endif
        default: begin
          state_r     <= IDLE;
          bit_valid_r <= 1'b0;
          bit_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule
